player_move_ctrl: RTL and testbench

Token movement sequencer sitting directly upstream of the per-player token register block. On a `start` pulse carrying a dice total, it drives that block's load/move strobes one pixel at a time along the board loop, advancing `spot` once per square until the roll is consumed, then pulses `done` to the game controller. Pixel counts per square come back from the token block's `moveSpaces`. Direction is derived from the board side of the current `spot`.

---
 rtl/board_pkg.sv | 36 +++
 rtl/pace_tick.sv | 30 +++
 rtl/player_move_ctrl.sv | 157 +++++++++++++++
 tb/tb_player_move_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared board definitions: FSM states, board-side codes and field widths.
package board_pkg;

    localparam int unsigned NUM_SPOTS = 32;
    localparam int unsigned SPOT_W    = 5;
    localparam int unsigned MOVE_W    = 6;
    localparam int unsigned STEPS_W   = 4;
    localparam int unsigned SIDE_W    = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MOVE   = 3'd2,
        ST_STEP   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } move_state_t;

    typedef enum logic [1:0] {
        SIDE_LEFT  = 2'd0,
        SIDE_UP    = 2'd1,
        SIDE_RIGHT = 2'd2,
        SIDE_DOWN  = 2'd3
    } side_t;

    // Board side is encoded in the top two bits of the square index.
    function automatic side_t side_of(input logic [SPOT_W-1:0] spot);
        return side_t'(spot[SPOT_W-1 -: SIDE_W]);
    endfunction

    // Left/right sides move along x, up/down sides along y.
    function automatic logic is_x_side(input side_t side);
        return (side == SIDE_LEFT) || (side == SIDE_RIGHT);
    endfunction

endpackage

// File: rtl/pace_tick.sv
// Free-running clock divider: one-cycle tick every DIV clocks, restarted by clr.
module pace_tick #(
    parameter int unsigned DIV = 250000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q;
    logic             at_end;

    assign at_end = (cnt_q == CNT_W'(DIV - 1));
    assign tick_c = at_end && !clr;

    // Count 0..DIV-1 and wrap; held at 0 while clr is asserted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (clr || at_end) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Token movement sequencer: walks a token square by square, one pixel strobe
// per tick, advancing spot once per square until the dice roll is consumed.
// Define PLAYER_MOVE_PACE_EN to pace pixel strobes to one per TICK_DIV clocks;
// otherwise one pixel moves per clock.
module player_move_ctrl
    import board_pkg::*;
#(
    parameter int unsigned TICK_DIV = 250000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [STEPS_W-1:0] steps,
    input  logic [SPOT_W-1:0]  spot,
    input  logic [MOVE_W-1:0]  move_spaces,
    output logic               ld_x,
    output logic               x_mv,
    output logic               ld_y,
    output logic               y_mv,
    output logic               right,
    output logic               down,
    output logic               ld_spot,
    output logic               busy,
    output logic               done,
    output logic               pass_go
);

    move_state_t        state_q, state_d;
    logic [STEPS_W-1:0] steps_left_q, steps_left_d;
    logic [MOVE_W-1:0]  pix_left_q, pix_left_d;
    side_t              side_q, side_d;

    logic x_stb_d, y_stb_d, ld_spot_d, pass_go_d, done_d, busy_d;
    logic right_d, down_d;
    logic tick_c;
    logic pace_clr;

    // Divider restarts on every entry to MOVE so the first strobe lands TICK_DIV clocks in.
    assign pace_clr = (state_q != ST_MOVE);

`ifdef PLAYER_MOVE_PACE_EN
    pace_tick #(
        .DIV (TICK_DIV)
    ) u_pace_tick (
        .clk    (clk),
        .resetn (resetn),
        .clr    (pace_clr),
        .tick_c (tick_c)
    );
`else
    logic unused_pace;
    assign unused_pace = pace_clr ^ (^TICK_DIV);
    assign tick_c      = 1'b1;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        steps_left_d = steps_left_q;
        pix_left_d   = pix_left_q;
        side_d       = side_q;
        right_d      = right;
        down_d       = down;
        x_stb_d      = 1'b0;
        y_stb_d      = 1'b0;
        ld_spot_d    = 1'b0;
        pass_go_d    = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    steps_left_d = steps;
                    state_d      = (steps == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                pix_left_d = move_spaces;
                side_d     = side_of(spot);
                right_d    = (side_of(spot) == SIDE_RIGHT);
                down_d     = (side_of(spot) == SIDE_DOWN);
                state_d    = ST_MOVE;
            end
            ST_MOVE: begin
                if (pix_left_q == '0) begin
                    state_d = ST_STEP;
                end else if (tick_c) begin
                    x_stb_d    = is_x_side(side_q);
                    y_stb_d    = !is_x_side(side_q);
                    pix_left_d = pix_left_q - MOVE_W'(1);
                    if (pix_left_q == MOVE_W'(1)) begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                ld_spot_d = 1'b1;
                pass_go_d = (spot == SPOT_W'(NUM_SPOTS - 1));
                if (steps_left_q != '0) begin
                    steps_left_d = steps_left_q - STEPS_W'(1);
                end
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Token block presents the new move_spaces one cycle after ld_spot.
                state_d = (steps_left_q == '0) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                right_d = 1'b0;
                down_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            steps_left_q <= '0;
            pix_left_q   <= '0;
            side_q       <= SIDE_LEFT;
            ld_x         <= 1'b0;
            x_mv         <= 1'b0;
            ld_y         <= 1'b0;
            y_mv         <= 1'b0;
            right        <= 1'b0;
            down         <= 1'b0;
            ld_spot      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_go      <= 1'b0;
        end else begin
            state_q      <= state_d;
            steps_left_q <= steps_left_d;
            pix_left_q   <= pix_left_d;
            side_q       <= side_d;
            ld_x         <= x_stb_d;
            x_mv         <= x_stb_d;
            ld_y         <= y_stb_d;
            y_mv         <= y_stb_d;
            right        <= right_d;
            down         <= down_d;
            ld_spot      <= ld_spot_d;
            busy         <= busy_d;
            done         <= done_d;
            pass_go      <= pass_go_d;
        end
    end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Scoreboard bench for player_move_ctrl with a behavioural token block.
module tb_player_move_ctrl;

    localparam int unsigned TICK_DIV = 4;
`ifdef PLAYER_MOVE_PACE_EN
    localparam int unsigned PACE = TICK_DIV;
`else
    localparam int unsigned PACE = 1;
`endif
    localparam int unsigned OUT_W = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [3:0] steps = 4'd0;
    logic [4:0] spot;
    logic [5:0] move_spaces;
    logic       ld_x, x_mv, ld_y, y_mv, right, down, ld_spot, busy, done, pass_go;

    logic       spot_wr = 1'b1;
    logic [4:0] spot_wr_val = 5'd0;
    logic [5:0] ms_table [32];

    logic [OUT_W-1:0] outs;
    logic [OUT_W-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    player_move_ctrl #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .steps       (steps),
        .spot        (spot),
        .move_spaces (move_spaces),
        .ld_x        (ld_x),
        .x_mv        (x_mv),
        .ld_y        (ld_y),
        .y_mv        (y_mv),
        .right       (right),
        .down        (down),
        .ld_spot     (ld_spot),
        .busy        (busy),
        .done        (done),
        .pass_go     (pass_go)
    );

    always #5 clk = ~clk;

    assign outs        = {ld_x, x_mv, ld_y, y_mv, right, down, ld_spot, pass_go, busy, done};
    assign move_spaces = ms_table[spot];

    // Token block model: spot register advanced by ld_spot, wrapping 31 -> 0.
    always @(posedge clk) begin
        if (spot_wr) spot <= spot_wr_val;
        else if (ld_spot) spot <= spot + 5'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got[OUT_W-1:0], exp[OUT_W-1:0], $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] mk(input logic sx, input logic sy, input logic r, input logic d,
                                            input logic lds, input logic pg, input logic b, input logic dn);
        return {sx, sx, sy, sy, r, d, lds, pg, b, dn};
    endfunction

    // Expected per-cycle outputs from the start edge through the done pulse.
    task automatic gen_move(input logic [4:0] sp0, input int n);
        logic [4:0] sp = sp0;
        logic pr = 1'b0;
        logic pd = 1'b0;
        for (int s = 0; s < n; s++) begin
            int   ms  = int'(ms_table[sp]);
            int   mv  = (ms == 0) ? 1 : ms * int'(PACE);
            logic r   = (sp[4:3] == 2'd2);
            logic d   = (sp[4:3] == 2'd3);
            logic isx = !sp[3];
            exp_q.push_back(mk(1'b0, 1'b0, pr, pd, 1'b0, 1'b0, 1'b1, 1'b0));
            for (int i = 1; i <= mv + 1; i++) begin
                logic stb = (i >= 2) && (((i - 2) % int'(PACE)) == int'(PACE) - 1) && ((i - 2) < ms * int'(PACE));
                exp_q.push_back(mk(stb & isx, stb & !isx, r, d, 1'b0, 1'b0, 1'b1, 1'b0));
            end
            exp_q.push_back(mk(1'b0, 1'b0, r, d, 1'b1, (sp == 5'd31), 1'b1, 1'b0));
            pr = r;
            pd = d;
            sp = sp + 5'd1;
        end
        exp_q.push_back(mk(1'b0, 1'b0, pr, pd, 1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back('0);
    endtask

    // Place token, pulse start, then pop/compare one expected word per cycle.
    task automatic kick(input string tag, input logic [4:0] sp, input logic [3:0] n,
                        input int inject_at, input int limit);
        int cyc = 0;
        spot_wr     = 1'b1;
        spot_wr_val = sp;
        @(posedge clk); #1;
        spot_wr = 1'b0;
        check_eq({tag, "_idle"}, 32'(outs), 32'(0));
        gen_move(sp, int'(n));
        start = 1'b1;
        steps = n;
        while (exp_q.size() > 0 && cyc < limit) begin
            logic [OUT_W-1:0] e;
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == inject_at) begin
                start = 1'b1;
                steps = 4'd9;
            end
            e = exp_q.pop_front();
            check_eq(tag, 32'(outs), 32'(e));
            cyc++;
        end
        start = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ms_table[i] = 6'((i * 7) % 23 + 2);
        ms_table[0]  = 6'd21;
        ms_table[7]  = 6'd41;
        ms_table[8]  = 6'd28;
        ms_table[13] = 6'd0;
        ms_table[16] = 6'd3;
        ms_table[31] = 6'd6;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset", 32'(outs), 32'(0));
        resetn = 1'b1;

        kick("sq_left",   5'd0,  4'd1, -1, 2000);
        kick("two_sq",    5'd7,  4'd2, -1, 2000);
        kick("pass_go",   5'd31, 4'd1, -1, 2000);
        kick("zero_step", 5'd5,  4'd0, -1, 2000);
        kick("ignore_st", 5'd12, 4'd3,  5, 2000);
        kick("paced",     5'd16, 4'd1, -1, 2000);
        kick("wrap",      5'd30, 4'd3, -1, 2000);

        // Abort mid-MOVE with reset, then confirm silence and a clean restart.
        kick("abort", 5'd3, 4'd2, -1, 8);
        resetn = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_now", 32'(outs), 32'(0));
        resetn = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check_eq("rst_quiet", 32'(outs), 32'(0));
        end
        kick("after_rst", 5'd24, 4'd2, -1, 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
